// File: rtl/udp_tx_pkg.sv
// Shared definitions for the UDP transmit packet buffer: launch FSM
// encoding, payload size limit and the width of the length field.
package udp_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SEND  = 3'd2,
    WAIT  = 3'd3,
    GAP   = 3'd4
  } tx_state_t;

  localparam int UDP_MAX_PAYLOAD = 1472;
  localparam int LEN_W           = 16;

endpackage

// File: rtl/udp_tx_len_fifo.sv
// Show-ahead FIFO of packet lengths: dout always presents the head entry,
// pop discards it. Push on full and pop on empty are ignored.
module udp_tx_len_fifo
  import udp_tx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [LEN_W-1:0] din,
  input  logic             pop,
  output logic [LEN_W-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [LEN_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Length storage; no reset needed, entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/udp_tx_pkt_buf.sv
// Packet buffer and launch sequencer feeding the UDP transmitter.
// Whole packets are stored in a payload RAM with their lengths queued in a
// small FIFO; each complete packet is launched once, served on tx_req and
// its RAM space is released on tx_done.
// Optional macro TX_PKT_STATS_EN adds sent/dropped packet counters.
module udp_tx_pkt_buf
  import udp_tx_pkg::*;
#(
  parameter int DATA_DEPTH    = 4096,
  parameter int LEN_DEPTH     = 16,
  parameter int MAX_PKT_BYTES = UDP_MAX_PAYLOAD,
  parameter int IFG_CYCLES    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             wr_last,
  output logic             wr_ready,
  output logic             pkt_drop,
  output logic             tx_start_en,
  output logic [LEN_W-1:0] tx_byte_num,
  input  logic             tx_req,
  output logic [7:0]       tx_data,
  input  logic             tx_done,
  output logic             busy,
  output logic             underrun
`ifdef TX_PKT_STATS_EN
  ,
  output logic [31:0]      pkt_sent_cnt,
  output logic [31:0]      pkt_drop_cnt
`endif
);

  localparam int ADDR_W = $clog2(DATA_DEPTH);
  localparam int GAP_W  = $clog2(IFG_CYCLES + 1);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  // Pointers carry one extra bit so a full RAM differs from an empty one.
  logic [7:0]       mem [DATA_DEPTH];
  logic [ADDR_W:0]  wp, ps, rp, rp_start, used, rp_end;
  logic [LEN_W-1:0] cnt, rem, len_dout;
  logic [GAP_W-1:0] gap_cnt;
  logic             discard, init_done, ram_full;
  logic             len_full, len_empty, len_push, len_pop;
  logic             accept, drop, in_pkt, rd_fire, rd_under;
  tx_state_t        state, state_nxt;

  assign used     = wp - rp_start;
  assign ram_full = (used == (ADDR_W+1)'(DATA_DEPTH));
  assign wr_ready = init_done && !ram_full && !len_full;
  assign len_push = accept && wr_last;
  assign in_pkt   = (state == SEND) || (state == WAIT);
  assign rd_fire  = in_pkt && tx_req && (rem != '0);
  assign rd_under = in_pkt && tx_req && (rem == '0);
  assign rp_end   = rp_start + (ADDR_W+1)'(tx_byte_num);

  udp_tx_len_fifo #(.DEPTH(LEN_DEPTH)) u_len_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (len_push),
    .din   (cnt + LEN_W'(1)),
    .pop   (len_pop),
    .dout  (len_dout),
    .full  (len_full),
    .empty (len_empty)
  );

  // Classify each incoming byte: ignored while discarding, dropped on any
  // overflow, otherwise accepted into the current packet.
  always_comb begin
    accept = 1'b0;
    drop   = 1'b0;
    if (wr_en && !discard) begin
      if (ram_full || (int'(cnt) + 1 > MAX_PKT_BYTES) || (wr_last && len_full))
        drop = 1'b1;
      else
        accept = 1'b1;
    end
  end

  // Payload RAM write port.
  always_ff @(posedge clk) begin
    if (accept) mem[wp[ADDR_W-1:0]] <= wr_data;
  end

  // Write-side pointers: commit at wr_last, rewind to packet start on drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp        <= '0;
      ps        <= '0;
      cnt       <= '0;
      discard   <= 1'b0;
      pkt_drop  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
      pkt_drop  <= drop;
      if (drop) begin
        wp      <= ps;
        cnt     <= '0;
        discard <= !wr_last;
      end else if (accept) begin
        wp <= wp + PTR_ONE;
        if (wr_last) begin
          ps  <= wp + PTR_ONE;
          cnt <= '0;
        end else begin
          cnt <= cnt + LEN_W'(1);
        end
      end else if (wr_en && discard && wr_last) begin
        discard <= 1'b0;
      end
    end
  end

  // Launch FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Launch FSM next state and strobes.
  always_comb begin
    state_nxt   = state;
    tx_start_en = 1'b0;
    len_pop     = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (!len_empty) begin
          len_pop   = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        tx_start_en = 1'b1;
        state_nxt   = SEND;
      end
      SEND: begin
        if (tx_done)                           state_nxt = GAP;
        else if (rd_fire && rem == LEN_W'(1))  state_nxt = WAIT;
      end
      WAIT: begin
        if (tx_done) state_nxt = GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_W'(IFG_CYCLES - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read-side datapath: registered RAM read, remaining count, resync of the
  // read pointer to the packet end on tx_done, and the inter-frame gap timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp          <= '0;
      rp_start    <= '0;
      rem         <= '0;
      tx_byte_num <= '0;
      tx_data     <= '0;
      underrun    <= 1'b0;
      gap_cnt     <= '0;
    end else begin
      if (len_pop) begin
        tx_byte_num <= len_dout;
        rem         <= len_dout;
      end
      if (rd_fire) begin
        tx_data <= mem[rp[ADDR_W-1:0]];
        rp      <= rp + PTR_ONE;
        rem     <= rem - LEN_W'(1);
      end else if (rd_under) begin
        tx_data  <= 8'h00;
        underrun <= 1'b1;
      end
      if (in_pkt && tx_done) begin
        rp       <= rp_end;
        rp_start <= rp_end;
      end
      gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
    end
  end

`ifdef TX_PKT_STATS_EN
  // Free-running packet statistics, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_sent_cnt <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      if (in_pkt && tx_done) pkt_sent_cnt <= pkt_sent_cnt + 32'd1;
      if (pkt_drop)          pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_udp_tx_pkt_buf.sv
// Testbench for udp_tx_pkt_buf: table of packet scenarios, directed
// multi-cycle sequences and a randomized phase against a packet-level model.
// Build with TX_PKT_STATS_EN defined to also check the statistics counters.
`timescale 1ns/1ps
module tb_udp_tx_pkt_buf;

  localparam int DATA_DEPTH = 2048;
  localparam int LEN_DEPTH  = 16;
  localparam int MAX_PKT    = 1472;
  localparam int IFG        = 12;
  localparam int TIMEOUT    = 20000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, wr_last = 1'b0, tx_req = 1'b0, tx_done = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_ready, pkt_drop, tx_start_en, busy, underrun;
  logic [15:0] tx_byte_num;
  logic [7:0]  tx_data;
`ifdef TX_PKT_STATS_EN
  logic [31:0] pkt_sent_cnt, pkt_drop_cnt;
`endif

  always #5 clk = ~clk;

  udp_tx_pkt_buf #(
    .DATA_DEPTH(DATA_DEPTH), .LEN_DEPTH(LEN_DEPTH),
    .MAX_PKT_BYTES(MAX_PKT), .IFG_CYCLES(IFG)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready), .pkt_drop(pkt_drop), .tx_start_en(tx_start_en),
    .tx_byte_num(tx_byte_num), .tx_req(tx_req), .tx_data(tx_data),
    .tx_done(tx_done), .busy(busy), .underrun(underrun)
`ifdef TX_PKT_STATS_EN
    , .pkt_sent_cnt(pkt_sent_cnt), .pkt_drop_cnt(pkt_drop_cnt)
`endif
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  exp_q[$];      // expected payload bytes, in transmit order
  logic [15:0] exp_len_q[$];  // expected lengths of accepted packets
  int  m_used = 0;            // bytes held by committed, not yet done packets
  int  m_accepted = 0;        // packets accepted since last reset
  int  m_sent = 0, m_drops = 0;
  bit  m_discard = 0, m_underrun = 0;
  int  st_base = 0, rd_idx = 0;
  int  last_done_cyc = -100;
  bit  wr_done = 0;

  // ---------------- monitor ----------------
  int  cyc = 0;
  int  start_len[$];
  int  start_cyc[$];
  int  start_double = 0;
  int  drop_seen = 0;
  logic prev_start = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every launch (length and cycle) and every drop pulse.
  always @(negedge clk) begin
    if (rst) begin
      prev_start <= 1'b0;
    end else begin
      if (tx_start_en) begin
        start_len.push_back(int'(tx_byte_num));
        start_cyc.push_back(cyc);
        if (prev_start) start_double++;
      end
      if (pkt_drop) drop_seen++;
      prev_start <= tx_start_en;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Length FIFO occupancy as the model sees it: accepted but not launched.
  function automatic int occ();
    return m_accepted - (start_len.size() - st_base);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic write_pkt(input int len, input int base, input bit rnd);
    logic [7:0] cur[$];
    int   partial;
    bit   last, drop_now, prev_drop;
    logic [7:0] b;
    partial   = 0;
    prev_drop = 0;
    for (int i = 0; i < len; i++) begin
      last = (i == len - 1);
      @(negedge clk);
      if (i > 0) check("pkt_drop", int'(pkt_drop), int'(prev_drop));
      b = rnd ? 8'($urandom_range(0, 255)) : 8'(base + i);
      drop_now = 0;
      if (m_discard) begin
        if (last) m_discard = 0;
      end else if ((m_used + partial >= DATA_DEPTH) || (partial + 1 > MAX_PKT) ||
                   (last && occ() >= LEN_DEPTH)) begin
        drop_now  = 1;
        partial   = 0;
        cur.delete();
        m_discard = !last;
        m_drops++;
      end else begin
        partial++;
        cur.push_back(b);
        if (last) begin
          m_used += partial;
          m_accepted++;
          exp_len_q.push_back(16'(partial));
          foreach (cur[k]) exp_q.push_back(cur[k]);
          partial = 0;
        end
      end
      wr_en   = 1'b1;
      wr_data = b;
      wr_last = last;
      prev_drop = drop_now;
    end
    @(negedge clk);
    check("pkt_drop", int'(pkt_drop), int'(prev_drop));
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic wait_start();
    int w = 0;
    while (rd_idx >= start_len.size() && w < TIMEOUT) begin
      @(negedge clk);
      w++;
    end
  endtask

  // Act as the transmitter for one packet: n_req byte requests, then tx_done.
  task automatic serve(input int n_req, input bit rnd_gap);
    int  exp_len, i, cnt;
    bit  req_now;
    logic [7:0] exp_b;
    wait_start();
    if (rd_idx >= start_len.size()) begin
      check("start_timeout", 0, 1);
      return;
    end
    if (exp_len_q.size() == 0) begin
      check("unexpected_start", 1, 0);
      return;
    end
    exp_len = int'(exp_len_q.pop_front());
    check("tx_byte_num", start_len[rd_idx], exp_len);
    check("start_after_gap", int'(start_cyc[rd_idx] > last_done_cyc + IFG), 1);
    rd_idx++;
    i = 0;
    while (i < n_req) begin
      @(negedge clk);
      req_now = !rnd_gap || ($urandom_range(0, 2) != 0);
      tx_req  = req_now;
      @(posedge clk);
      #1;
      if (req_now) begin
        exp_b = (i < exp_len) ? exp_q.pop_front() : 8'h00;
        check("tx_data", int'(tx_data), int'(exp_b));
        i++;
      end
    end
    for (int k = n_req; k < exp_len; k++) void'(exp_q.pop_front());
    if (n_req > exp_len) m_underrun = 1;
    @(negedge clk);
    tx_req  = 1'b0;
    tx_done = 1'b1;
    check("tx_byte_num_hold", int'(tx_byte_num), exp_len);
    @(posedge clk);
    #1;
    last_done_cyc = cyc;
    m_used -= exp_len;
    m_sent++;
    @(negedge clk);
    tx_done = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_gap_cycles", cnt, IFG);
    check("underrun", int'(underrun), int'(m_underrun));
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_len_q.delete();
    m_used = 0; m_accepted = 0; m_sent = 0; m_drops = 0;
    m_discard = 0; m_underrun = 0;
    st_base = start_len.size();
    rd_idx  = st_base;
    last_done_cyc = -100;
  endtask

  task automatic check_stats(input string tag);
`ifdef TX_PKT_STATS_EN
    check({tag, "_pkt_sent_cnt"}, int'(pkt_sent_cnt), m_sent);
    check({tag, "_pkt_drop_cnt"}, int'(pkt_drop_cnt), m_drops);
`else
    check({tag, "_drop_count"}, drop_seen, drop_seen);
`endif
  endtask

  // ---------------- table of packet scenarios ----------------
  typedef struct {
    int len;
    int n_req;
    bit accept;
    bit underrun;
  } vec_t;
  vec_t vec[7];

  initial begin
    int ds, ss, w, len, r, nreq;
    vec[0] = '{18,   18,   1'b1, 1'b0};  // basic packet 0x00..0x11
    vec[1] = '{1480, 0,    1'b0, 1'b0};  // overlong: drop at byte 1473
    vec[2] = '{10,   10,   1'b1, 1'b0};  // recovers after drop
    vec[3] = '{1472, 1472, 1'b1, 1'b0};  // largest legal payload
    vec[4] = '{1,    1,    1'b1, 1'b0};  // single byte
    vec[5] = '{18,   20,   1'b1, 1'b1};  // two extra requests -> underrun
    vec[6] = '{7,    7,    1'b1, 1'b1};  // data realigned, underrun sticky

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_start_en", int'(tx_start_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pkt_drop", int'(pkt_drop), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_tx_byte_num", int'(tx_byte_num), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("wr_ready_after_rst", int'(wr_ready), 1);

    // table-driven packets
    for (int k = 0; k < 7; k++) begin
      ds = drop_seen;
      ss = start_len.size();
      write_pkt(vec[k].len, 0, k != 0);
      repeat (4) @(negedge clk);
      check("vec_drop", drop_seen - ds, vec[k].accept ? 0 : 1);
      if (vec[k].accept) serve(vec[k].n_req, 0);
      else check("vec_no_start", start_len.size() - ss, 0);
      check("vec_underrun", int'(underrun), int'(vec[k].underrun));
    end

    // three packets queued back-to-back; payload wraps the RAM
    write_pkt(5, 8'h20, 0);
    write_pkt(1, 8'h80, 0);
    write_pkt(1472, 0, 1);
    serve(5, 0);
    serve(1, 0);
    serve(1472, 0);
    check_stats("b2b");

    // fill the length FIFO behind one packet in flight
    write_pkt(4, 8'h30, 0);
    wait_start();
    repeat (3) @(negedge clk);
    for (int p = 0; p < LEN_DEPTH; p++) write_pkt(3, 8'h50 + p, 0);
    ds = drop_seen;
    write_pkt(3, 8'h70, 0);
    repeat (2) @(negedge clk);
    check("fill_drop", drop_seen - ds, 1);
    check("fill_wr_ready", int'(wr_ready), 0);
    serve(4, 0);
    w = 0;
    while (!wr_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("wr_ready_after_done", int'(wr_ready), 1);
    for (int p = 0; p < LEN_DEPTH; p++) serve(3, 0);
    check_stats("fill");

    // reset in the middle of a packet
    write_pkt(10, 8'h40, 0);
    wait_start();
    repeat (3) begin
      @(negedge clk) tx_req = 1'b1;
      @(posedge clk);
    end
    @(negedge clk) tx_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_tx_start_en", int'(tx_start_en), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_tx_data", int'(tx_data), 0);
    check("midrst_tx_byte_num", int'(tx_byte_num), 0);
    check("midrst_underrun", int'(underrun), 0);
    check("midrst_pkt_drop", int'(pkt_drop), 0);
    check("midrst_wr_ready", int'(wr_ready), 0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("wr_ready_after_midrst", int'(wr_ready), 1);
    ss = start_len.size();
    repeat (20) @(negedge clk);
    check("queue_empty_after_rst", start_len.size() - ss, 0);
    write_pkt(4, 8'hA0, 0);
    serve(4, 0);
    check_stats("midrst");

    // randomized traffic: writer and transmitter run concurrently
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          w = 0;
          while (exp_len_q.size() > 5 && w < TIMEOUT) begin
            @(negedge clk);
            w++;
          end
          len = ($urandom_range(0, 9) == 0) ? $urandom_range(MAX_PKT + 1, MAX_PKT + 18)
                                            : $urandom_range(1, 64);
          write_pkt(len, 0, 1);
          repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        wr_done = 1;
      end
      begin
        forever begin
          int wt = 0;
          while (exp_len_q.size() == 0 && !wr_done && wt < TIMEOUT) begin
            @(negedge clk);
            wt++;
          end
          if (exp_len_q.size() == 0) begin
            if (!wr_done) check("rand_wait_timeout", 0, 1);
            break;
          end
          len  = int'(exp_len_q[0]);
          r    = $urandom_range(0, 7);
          nreq = (r == 0) ? len + 1 : ((r == 1 && len > 1) ? len - 1 : len);
          serve(nreq, 1);
        end
      end
    join
    repeat (20) @(negedge clk);
    check("rand_bytes_left", exp_q.size(), 0);
    check("rand_no_extra_start", start_len.size() - rd_idx, 0);
    check("start_single_cycle", start_double, 0);
    check_stats("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
